load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding bus access with lane steering, load extension and a REQ timeout.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with BusErr instead of issuing them.
module load_store_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] ALUResult,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             MemRead,
   input  logic             MemWrite,
   input  logic [2:0]       funct3,
   output logic             Stall,
   output logic [WIDTH-1:0] ReadData,
   output logic             ReadValid,
   output logic             BusErr,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_be,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   // Store encodings 100/101 are not legal, so they fall through to word like any other unsupported value.
   function automatic size_t decode_size(input logic [2:0] f3, input logic store);
      size_t sz;
      sz = SZ_WORD;
      if (f3 == 3'b000 || (!store && f3 == 3'b100))
         sz = SZ_BYTE;
      else if (f3 == 3'b001 || (!store && f3 == 3'b101))
         sz = SZ_HALF;
      return sz;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [2:0]       funct3_q, funct3_d;
   logic             we_q, we_d;
   logic             err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   size_t            acc_size;
   logic [7:0]       byte_lane;
   logic [15:0]      half_lane;
   logic [3:0]       lane_be;
   logic [WIDTH-1:0] lane_wdata;
   logic [WIDTH-1:0] load_data;
   logic             misalign;

`ifdef LSU_MISALIGN_TRAP_EN
   size_t req_size;
   assign req_size = decode_size(funct3, MemWrite);
   assign misalign = (req_size == SZ_HALF && ALUResult[0]) ||
                     (req_size == SZ_WORD && ALUResult[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign acc_size  = decode_size(funct3_q, we_q);
   assign byte_lane = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
   assign half_lane = 16'(mem_rdata >> {addr_q[1], 4'b0000});

   always_comb begin
      lane_be    = 4'b1111;
      lane_wdata = wdata_q;
      load_data  = mem_rdata;
      case (acc_size)
         SZ_BYTE: begin
            lane_be    = 4'b0001 << addr_q[1:0];
            lane_wdata = {(WIDTH/8){wdata_q[7:0]}};
            load_data  = funct3_q[2] ? {{(WIDTH-8){1'b0}}, byte_lane}
                                     : {{(WIDTH-8){byte_lane[7]}}, byte_lane};
         end
         SZ_HALF: begin
            lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {(WIDTH/16){wdata_q[15:0]}};
            load_data  = funct3_q[2] ? {{(WIDTH-16){1'b0}}, half_lane}
                                     : {{(WIDTH-16){half_lane[15]}}, half_lane};
         end
         default: begin
            lane_be    = 4'b1111;
            lane_wdata = wdata_q;
            load_data  = mem_rdata;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      funct3_d = funct3_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      Stall    = 1'b0;
      mem_req  = 1'b0;
      case (state_q)
         IDLE: begin
            if (MemRead || MemWrite) begin
               Stall    = 1'b1;
               addr_d   = ALUResult;
               wdata_d  = WriteData;
               funct3_d = funct3;
               we_d     = MemWrite;
               cnt_d    = '0;
               if (misalign) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            Stall   = 1'b1;
            mem_req = 1'b1;
            if (mem_ack) begin
               state_d = DONE;
               if (!we_q)
                  rdata_d = load_data;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         funct3_q <= funct3_d;
         we_q     <= we_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
   assign mem_we    = mem_req & we_q;
   assign mem_be    = mem_req ? lane_be : 4'b0000;
   assign mem_wdata = lane_wdata;
   assign ReadData  = rdata_q;
   assign BusErr    = err_q;
   // Error completions reuse DONE but must never present data as valid.
   assign ReadValid = (state_q == DONE) && !we_q && !err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a per-cycle expected timeline built from access-level rules, plus literal pins.
module tb_load_store_unit;
   localparam int W  = 32;
   localparam int TO = 16;
   localparam int N  = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  ALUResult = '0, WriteData = '0, ReadData, mem_addr, mem_wdata, mem_rdata = '0;
   logic          MemRead = 1'b0, MemWrite = 1'b0, Stall, ReadValid, BusErr;
   logic          mem_req, mem_we, mem_ack = 1'b0;
   logic [2:0]    funct3 = '0;
   logic [3:0]    mem_be;

   load_store_unit #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ALUResult(ALUResult), .WriteData(WriteData),
      .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3), .Stall(Stall),
      .ReadData(ReadData), .ReadValid(ReadValid), .BusErr(BusErr), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0, miscompares = 0;
   bit checking = 0;

   logic        e_stall[N], e_req[N], e_we[N], e_rv[N], e_err[N], e_chkrd[N];
   logic [3:0]  e_be[N];
   logic [31:0] e_addr[N], e_wd[N], e_rd[N];

   logic [31:0] last_addr = '0, last_wd = '0, last_rd = '0;
   logic [3:0]  last_be = '0;
   int          req_cnt = 0, err_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("Stall", 32'(Stall), 32'(e_stall[cyc]));
         chk("mem_req", 32'(mem_req), 32'(e_req[cyc]));
         chk("mem_we", 32'(mem_we), 32'(e_we[cyc]));
         chk("mem_be", 32'(mem_be), 32'(e_be[cyc]));
         chk("ReadValid", 32'(ReadValid), 32'(e_rv[cyc]));
         chk("BusErr", 32'(BusErr), 32'(e_err[cyc]));
         if (e_req[cyc]) begin
            chk("mem_addr", mem_addr, e_addr[cyc]);
            chk("mem_wdata", mem_wdata, e_wd[cyc]);
         end
         if (e_chkrd[cyc]) chk("ReadData", ReadData, e_rd[cyc]);
         if (mem_req) begin
            req_cnt++;
            last_addr = mem_addr;
            last_be   = mem_be;
            last_wd   = mem_wdata;
         end
         if (ReadValid) last_rd = ReadData;
         if (BusErr) err_cnt++;
      end
   end

   // 0 = byte, 1 = half, 2 = word
   function automatic int msize(input logic [2:0] f3, input bit st);
      if (f3 == 3'b000) return 0;
      if (f3 == 3'b001) return 1;
      if (!st && f3 == 3'b100) return 0;
      if (!st && f3 == 3'b101) return 1;
      return 2;
   endfunction

   function automatic logic [3:0] mbe(input int sz, input logic [31:0] a);
      logic [31:0] t;
      if (sz == 0) t = 32'd1 << (a % 4);
      else if (sz == 1) t = 32'd3 << (2 * ((a / 2) % 2));
      else t = 32'hF;
      return t[3:0];
   endfunction

   function automatic logic [31:0] mwd(input int sz, input logic [31:0] d);
      if (sz == 0) return (d & 32'hFF) * 32'h01010101;
      if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] mld(input int sz, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
      logic [31:0] v;
      if (sz == 0) begin
         v = (r >> (8 * (a % 4))) & 32'hFF;
         if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 1) begin
         v = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end else begin
         v = r;
      end
      return v;
   endfunction

   function automatic bit mtrap(input int sz, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`else
      return (sz < 0) && (a == 0);
`endif
   endfunction

   task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input int ack_dly, input logic [31:0] rdat,
                         input int rst_at, input bit stray_ack);
      int c0, n, sz;
      bit st, acked;
      @(posedge clk); #1;
      c0 = cyc;
      MemRead = rd; MemWrite = wr; ALUResult = a; WriteData = d; funct3 = f3; mem_ack = 1'b0;
      st = wr;
      sz = msize(f3, st);
      e_stall[c0] = 1'b1;
      if (mtrap(sz, a)) begin
         e_err[c0+1] = 1'b1; e_chkrd[c0+1] = 1'b1; e_rd[c0+1] = '0;
         @(posedge clk); #1;
         MemRead = 1'b0; MemWrite = 1'b0; mem_ack = stray_ack;
         @(posedge clk); #1;
         mem_ack = 1'b0;
         return;
      end
      acked = (ack_dly >= 0) && (ack_dly < TO);
      n = acked ? ack_dly + 1 : TO;
      for (int i = 1; i <= n; i++) begin
         if (rst_at == 0 || i <= rst_at) begin
            e_stall[c0+i] = 1'b1; e_req[c0+i] = 1'b1; e_we[c0+i] = st;
            e_be[c0+i] = mbe(sz, a); e_addr[c0+i] = a & ~32'd3; e_wd[c0+i] = mwd(sz, d);
         end
      end
      if (rst_at > 0) begin
         for (int i = rst_at + 1; i <= n + 2; i++) begin
            e_chkrd[c0+i] = 1'b1; e_rd[c0+i] = '0;
         end
      end else begin
         e_rv[c0+n+1]    = !st && acked;
         e_err[c0+n+1]   = !acked;
         e_chkrd[c0+n+1] = !st;
         e_rd[c0+n+1]    = acked ? mld(sz, f3, a, rdat) : 32'd0;
      end
      for (int i = 1; i <= n; i++) begin
         @(posedge clk); #1;
         MemRead = 1'b0; MemWrite = 1'b0;
         rst_n = !(rst_at == i);
         mem_ack = acked && (i == ack_dly + 1);
         mem_rdata = mem_ack ? rdat : 32'hA5A5_5A5A;
      end
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ack = stray_ack; mem_rdata = 32'h1357_9BDF;
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         e_stall[i] = 0; e_req[i] = 0; e_we[i] = 0; e_rv[i] = 0; e_err[i] = 0; e_chkrd[i] = 0;
         e_be[i] = '0; e_addr[i] = '0; e_wd[i] = '0; e_rd[i] = '0;
      end
      for (int i = 1; i <= 4; i++) e_chkrd[i] = 1'b1;
      @(posedge clk); #1;
      checking = 1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // SW 0x100, zero wait states
      access(0, 1, 32'h100, 32'hDEADBEEF, 3'b010, 0, '0, 0, 0);
      chk("sw_addr", last_addr, 32'h100);
      chk("sw_be", 32'(last_be), 32'h0000000F);
      chk("sw_wdata", last_wd, 32'hDEADBEEF);

      // LB / LBU at 0x103
      access(1, 0, 32'h103, '0, 3'b000, 0, 32'h80FFFFFF, 0, 0);
      chk("lb_data", last_rd, 32'hFFFFFF80);
      access(1, 0, 32'h103, '0, 3'b100, 2, 32'h80FFFFFF, 0, 1);
      chk("lbu_data", last_rd, 32'h00000080);

      // SH 0x102
      access(0, 1, 32'h102, 32'h0000ABCD, 3'b001, 1, '0, 0, 0);
      chk("sh_be", 32'(last_be), 32'h0000000C);
      chk("sh_wdata", last_wd, 32'hABCDABCD);
      chk("sh_addr", last_addr, 32'h100);

      // LW, ack never comes
      req_cnt = 0; err_cnt = 0;
      access(1, 0, 32'h200, '0, 3'b010, -1, '0, 0, 0);
      chk("to_req_cycles", 32'(req_cnt), 32'd16);
      chk("to_buserr_pulses", 32'(err_cnt), 32'd1);

      // LW, ack after 5 cycles, reset in 3rd REQ cycle
      req_cnt = 0;
      access(1, 0, 32'h204, '0, 3'b010, 5, 32'h11111111, 3, 0);
      chk("rst_req_cycles", 32'(req_cnt), 32'd3);

      // LH 0x101
      last_be = '0; err_cnt = 0; req_cnt = 0;
      access(1, 0, 32'h101, '0, 3'b001, 0, 32'h12348765, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("lh_mis_err", 32'(err_cnt), 32'd1);
      chk("lh_mis_noreq", 32'(req_cnt), 32'd0);
`else
      chk("lh_mis_be", 32'(last_be), 32'h00000003);
      chk("lh_mis_data", last_rd, 32'hFFFF8765);
`endif

      access(1, 0, 32'h102, '0, 3'b101, 0, 32'h87651234, 0, 0);
      chk("lhu_data", last_rd, 32'h00008765);
      access(1, 0, 32'h102, '0, 3'b001, 3, 32'h87651234, 0, 0);
      access(0, 1, 32'h101, 32'h1234565A, 3'b000, 0, '0, 0, 0);
      chk("sb_wdata", last_wd, 32'h5A5A5A5A);
      chk("sb_be", 32'(last_be), 32'h00000002);
      access(1, 0, 32'h104, '0, 3'b010, 3, 32'hCAFEF00D, 0, 1);
      access(1, 0, 32'h108, '0, 3'b011, 0, 32'h0BADC0DE, 0, 0);
      access(0, 1, 32'h10C, 32'h11223344, 3'b100, 0, '0, 0, 0);
      access(1, 1, 32'h110, 32'h55667788, 3'b000, 0, 32'hFFFFFFFF, 0, 0);
      access(1, 0, 32'h10A, '0, 3'b010, 1, 32'h76543210, 0, 0);
      access(1, 0, 32'h10E, '0, 3'b100, TO - 1, 32'h9ABCDEF0, 0, 0);

      // stray ack while idle
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
